hold_digitize_sequencer: RTL and testbench
==========================================

HOLD_DIGITIZE_SEQUENCER -- requirements
Module: hold_digitize_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: number of flip-flop synchroniser stages on hold_i.
REQ-002 The block SHALL have parameter DONE_TIMEOUT, default 65535: number of clk_i cycles to wait for done_i before abandoning a buffer.
REQ-003 The block SHALL have port clk_i, input, 1 bit: 33 MHz system clock; it is the only clock.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port hold_i, input, 4 bits: raw TURF HOLD level for each of LAB buffers 0-3; asynchronous to clk_i.
REQ-006 The block SHALL have port digitize_o, output, 4 bits: one-hot, single-cycle digitize strobe to the LAB readout.
REQ-007 The block SHALL have port done_i, input, 1 bit: single-cycle pulse from the LAB readout when digitisation is complete.
REQ-008 The block SHALL have port event_ready_o, output, 1 bit: a digitised buffer is available to the register interface.
REQ-009 The block SHALL have port event_buf_o, output, 2 bits: index of the buffer in service.
REQ-010 The block SHALL have port event_ack_i, input, 1 bit: single-cycle pulse from the register interface when the buffer has been read.
REQ-011 The block SHALL have port busy_o, output, 1 bit: all four buffers pending.
REQ-012 The block SHALL have port err_o, output, 1 bit: sticky flag, set when a done_i timeout occurs.
REQ-013 The block SHALL have port dup_cnt_o, output, 8 bits: saturating count of HOLD rising edges seen on buffers that are already pending.

Function
REQ-014 Each hold_i bit SHALL pass through SYNC_STAGES flip-flops, followed by one registered rising-edge detector.
REQ-015 A detected rising edge on bit n SHALL set pending[n] on the next cycle.
REQ-016 If pending[n] is already set when that edge is detected, pending[n] SHALL stay set and dup_cnt_o SHALL increment, saturating at 255.
REQ-017 Falling edges of hold_i SHALL have no effect on pending[n].
REQ-018 The FSM SHALL have the states IDLE, DIGITIZE, WAIT_DONE and READY.
REQ-019 In IDLE, if any pending bit is set, the FSM SHALL latch the lowest-indexed pending buffer into event_buf_o and go to DIGITIZE.
REQ-020 In DIGITIZE, digitize_o[event_buf_o] SHALL be high for exactly one cycle, after which the FSM goes to WAIT_DONE.
REQ-021 Latency from the synchronised edge to digitize_o SHALL be no more than 3 cycles when the FSM is in IDLE.
REQ-022 In WAIT_DONE, done_i SHALL move the FSM to READY.
REQ-023 In WAIT_DONE, if DONE_TIMEOUT cycles elapse without done_i, the FSM SHALL set err_o, clear pending[event_buf_o] and return to IDLE.
REQ-024 In READY, event_ready_o SHALL be high.
REQ-025 In READY, event_ack_i SHALL clear pending[event_buf_o], drop event_ready_o on the next cycle and return the FSM to IDLE.
REQ-026 done_i outside WAIT_DONE and event_ack_i outside READY SHALL be ignored.
REQ-027 When a rising edge arrives on the in-service buffer, it SHALL be handled as a duplicate per REQ-016.
REQ-028 When a buffer is set pending in the same cycle that it is cleared, the set SHALL win, so the buffer is requeued.
REQ-029 busy_o SHALL equal the AND of pending[3:0] and SHALL be registered.
REQ-030 err_o SHALL clear only on reset.
REQ-031 The timeout counter SHALL be 16 bits wide, loaded on entry to WAIT_DONE, with no wrap.

Reset
REQ-032 When rst_n_i is low, the block SHALL asynchronously clear the synchronisers, edge registers, pending, the FSM (to IDLE), the timeout counter, digitize_o, event_ready_o, event_buf_o, busy_o, err_o and dup_cnt_o, all to 0.
REQ-033 A reset during DIGITIZE, WAIT_DONE or READY SHALL abandon the buffer without issuing digitize_o.
REQ-034 Release of rst_n_i SHALL be synchronised externally, so the block needs no deassertion logic of its own.

Structure
REQ-035 The FSM state encoding, the buffer count (4) and the dup-counter width SHALL live in the shared SURF package.
REQ-036 The hold_i synchroniser plus edge detector SHALL be a single sub-module, hold_sync_edge, instantiated once and 4 bits wide.

Verification
REQ-037 Bench: hold_i=4'b0100 rising -> within 3 cycles digitize_o=4'b0100 for 1 cycle; done_i -> event_ready_o=1 and event_buf_o=2; event_ack_i -> event_ready_o=0 and busy_o=0.
REQ-038 Bench: hold_i 0->4'b1011 simultaneously -> buffers serviced in order 0, 1, 3, each waiting for its own done_i and ack.
REQ-039 Bench: all four HOLDs -> busy_o=1; after the first ack, busy_o=0.
REQ-040 Bench: done_i withheld with DONE_TIMEOUT=100 -> err_o=1 after 100 cycles, the FSM goes to IDLE and the next pending buffer is digitised.
REQ-041 Bench: hold_i[1] toggled 300 times while buffer 1 is pending -> dup_cnt_o=255.
REQ-042 Bench: rst_n_i pulsed low during WAIT_DONE -> all outputs 0 immediately; a later done_i is ignored.

Source files
------------

// File: rtl/hold_digitize_sequencer_pkg.sv
// Shared SURF definitions for the HOLD -> digitize sequencer: buffer count,
// sequencer state encoding and counter widths.
package hold_digitize_sequencer_pkg;

  localparam int NUM_BUFS  = 4;
  localparam int BUF_IDX_W = 2;
  localparam int DUP_CNT_W = 8;
  localparam int TMO_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIGITIZE  = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_READY     = 2'd3
  } seq_state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [BUF_IDX_W-1:0] lowest_set(input logic [NUM_BUFS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = BUF_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/hold_digitize_sequencer_sync_edge.sv
// Multi-stage synchroniser for the asynchronous HOLD levels, followed by a
// registered rising-edge detector producing one-cycle pulses.
module hold_sync_edge
  import hold_digitize_sequencer_pkg::*;
#(
  parameter int WIDTH       = NUM_BUFS,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/hold_digitize_sequencer.sv
// Queues TURF HOLD requests per LAB buffer and walks each one through
// digitize, wait-for-done and register-readout handshake, lowest index first.
module hold_digitize_sequencer
  import hold_digitize_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_BUFS-1:0]  hold_i,
  output logic [NUM_BUFS-1:0]  digitize_o,
  input  logic                 done_i,
  output logic                 event_ready_o,
  output logic [BUF_IDX_W-1:0] event_buf_o,
  input  logic                 event_ack_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [DUP_CNT_W-1:0] dup_cnt_o
);

  logic [NUM_BUFS-1:0]  rise;
  logic [NUM_BUFS-1:0]  pending_q, pending_d;
  logic [NUM_BUFS-1:0]  clr;
  logic [NUM_BUFS-1:0]  dup;
  logic [2:0]           dup_n;
  logic [DUP_CNT_W:0]   dup_sum;
  logic [DUP_CNT_W-1:0] dup_cnt_q, dup_cnt_d;
  logic                 busy_q;

  seq_state_e           state_q;
  logic [BUF_IDX_W-1:0] buf_q;
  logic [BUF_IDX_W-1:0] first_idx;
  logic [TMO_W-1:0]     tmo_q;
  logic [NUM_BUFS-1:0]  digitize_q;
  logic                 ready_q;
  logic                 err_q;
  logic                 timeout;
  logic                 ack_hit;

  hold_sync_edge #(
    .WIDTH      (NUM_BUFS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .async_i(hold_i),
    .rise_o (rise)
  );

  assign first_idx = lowest_set(pending_q);
  assign timeout   = (state_q == ST_WAIT_DONE) && !done_i && (tmo_q <= TMO_W'(1));
  assign ack_hit   = (state_q == ST_READY) && event_ack_i;

  // A new edge ORs in after the clear, so a same-cycle set requeues the buffer.
  always_comb begin
    clr = '0;
    if (timeout || ack_hit) clr[buf_q] = 1'b1;
    dup       = rise & pending_q;
    pending_d = (pending_q & ~clr) | rise;
    dup_n     = '0;
    for (int i = 0; i < NUM_BUFS; i++) dup_n = dup_n + 3'(dup[i]);
    dup_sum   = {1'b0, dup_cnt_q} + (DUP_CNT_W+1)'(dup_n);
    dup_cnt_d = dup_sum[DUP_CNT_W] ? '1 : dup_sum[DUP_CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
      busy_q    <= 1'b0;
      dup_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= &pending_d;
      dup_cnt_q <= dup_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      tmo_q      <= '0;
      digitize_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      digitize_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|pending_q) begin
            buf_q      <= first_idx;
            digitize_q <= NUM_BUFS'(1) << first_idx;
            state_q    <= ST_DIGITIZE;
          end
        end
        ST_DIGITIZE: begin
          tmo_q   <= TMO_W'(DONE_TIMEOUT);
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (done_i) begin
            ready_q <= 1'b1;
            state_q <= ST_READY;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
          end
        end
        ST_READY: begin
          if (event_ack_i) begin
            ready_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign digitize_o    = digitize_q;
  assign event_ready_o = ready_q;
  assign event_buf_o   = buf_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign dup_cnt_o     = dup_cnt_q;

endmodule

// File: tb/tb_hold_digitize_sequencer.sv
// Directed bench for hold_digitize_sequencer: single and multi-buffer service,
// busy, done timeout, duplicate counting, requeue and reset abandonment.
module tb_hold_digitize_sequencer;

  logic       clk_i       = 1'b0;
  logic       rst_n_i     = 1'b0;
  logic [3:0] hold_i      = 4'b0;
  logic       done_i      = 1'b0;
  logic       event_ack_i = 1'b0;
  logic [3:0] digitize_o;
  logic       event_ready_o;
  logic [1:0] event_buf_o;
  logic       busy_o;
  logic       err_o;
  logic [7:0] dup_cnt_o;

  int checks = 0;
  int errors = 0;

  hold_digitize_sequencer #(
    .SYNC_STAGES (2),
    .DONE_TIMEOUT(100)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .hold_i       (hold_i),
    .digitize_o   (digitize_o),
    .done_i       (done_i),
    .event_ready_o(event_ready_o),
    .event_buf_o  (event_buf_o),
    .event_ack_i  (event_ack_i),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .dup_cnt_o    (dup_cnt_o)
  );

  always #15 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a digitize strobe, checks its value, latency bound and width.
  task automatic wait_dig(input string tag, input logic [3:0] exp, input int max_lat);
    int lat;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (digitize_o == 4'b0 && lat < 20);
    chk({tag, " strobe"}, digitize_o, exp);
    chk({tag, " latency"}, (lat <= max_lat), 1);
    $display("txn %s: digitize_o=%b after %0d cycles", tag, digitize_o, lat);
    tick();
    chk({tag, " one-cycle"}, digitize_o, 0);
  endtask

  task automatic finish_buf(input string tag, input logic [1:0] b);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk({tag, " ready"}, event_ready_o, 1);
    chk({tag, " buf"}, event_buf_o, b);
    event_ack_i = 1'b1;
    tick();
    event_ack_i = 1'b0;
    chk({tag, " ready drop"}, event_ready_o, 0);
    $display("txn %s: buffer %0d done and acknowledged", tag, b);
  endtask

  initial begin
    int cnt;

    // Reset state
    tick();
    tick();
    chk("rst digitize", digitize_o, 0);
    chk("rst ready", event_ready_o, 0);
    chk("rst buf", event_buf_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst err", err_o, 0);
    chk("rst dup", dup_cnt_o, 0);
    rst_n_i = 1'b1;
    tick();

    // Single buffer 2; an ack during WAIT_DONE must be ignored
    hold_i = 4'b0100;
    wait_dig("t1", 4'b0100, 5);
    event_ack_i = 1'b1;
    tick();
    event_ack_i = 1'b0;
    chk("t1 early ack ignored", event_ready_o, 0);
    finish_buf("t1", 2'd2);
    chk("t1 busy", busy_o, 0);

    // Falling edge leaves nothing pending
    hold_i = 4'b0000;
    repeat (6) tick();
    chk("fall no strobe", digitize_o, 0);

    // Simultaneous 1011 serviced as 0, 1, 3
    hold_i = 4'b1011;
    wait_dig("t2 b0", 4'b0001, 5);
    chk("t2 busy", busy_o, 0);
    finish_buf("t2 b0", 2'd0);
    wait_dig("t2 b1", 4'b0010, 2);
    finish_buf("t2 b1", 2'd1);
    wait_dig("t2 b3", 4'b1000, 2);
    finish_buf("t2 b3", 2'd3);
    hold_i = 4'b0000;
    repeat (6) tick();

    // All four pending -> busy until the first ack
    hold_i = 4'b1111;
    wait_dig("t3 b0", 4'b0001, 5);
    chk("t3 busy set", busy_o, 1);
    finish_buf("t3 b0", 2'd0);
    chk("t3 busy clear", busy_o, 0);
    wait_dig("t3 b1", 4'b0010, 2);
    finish_buf("t3 b1", 2'd1);
    wait_dig("t3 b2", 4'b0100, 2);
    finish_buf("t3 b2", 2'd2);
    wait_dig("t3 b3", 4'b1000, 2);
    finish_buf("t3 b3", 2'd3);
    hold_i = 4'b0000;
    repeat (6) tick();

    // done_i withheld: timeout after 100 WAIT_DONE cycles, then next buffer
    hold_i = 4'b0011;
    wait_dig("t4 b0", 4'b0001, 5);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!err_o && cnt < 300);
    chk("t4 err", err_o, 1);
    chk("t4 timeout cycles", cnt, 100);
    chk("t4 ready", event_ready_o, 0);
    $display("txn t4: timeout after %0d cycles", cnt);
    wait_dig("t4 b1", 4'b0010, 1);
    finish_buf("t4 b1", 2'd1);
    chk("t4 err sticky", err_o, 1);
    hold_i = 4'b0000;
    repeat (6) tick();

    // Duplicate edges on buffer 1 while it sits in READY
    chk("t5 dup start", dup_cnt_o, 0);
    hold_i = 4'b0010;
    wait_dig("t5 b1", 4'b0010, 5);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("t5 ready", event_ready_o, 1);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("t5 done in ready ignored", event_ready_o, 1);
    hold_i = 4'b0000;
    tick();
    repeat (10) begin
      hold_i = 4'b0010;
      tick();
      hold_i = 4'b0000;
      tick();
    end
    repeat (4) tick();
    chk("t5 dup 10", dup_cnt_o, 10);
    repeat (290) begin
      hold_i = 4'b0010;
      tick();
      hold_i = 4'b0000;
      tick();
    end
    repeat (4) tick();
    chk("t5 dup saturate", dup_cnt_o, 255);
    $display("txn t5: dup_cnt_o=%0d after 300 duplicate edges", dup_cnt_o);

    // Edge lands on the same cycle as the ack clear -> buffer 1 requeued
    hold_i = 4'b0010;
    repeat (3) tick();
    event_ack_i = 1'b1;
    tick();
    event_ack_i = 1'b0;
    chk("t5 ack drop", event_ready_o, 0);
    wait_dig("t5 requeue", 4'b0010, 1);
    finish_buf("t5 requeue", 2'd1);
    hold_i = 4'b0000;
    repeat (6) tick();

    // Reset during WAIT_DONE abandons the buffer; later done_i ignored
    hold_i = 4'b0100;
    wait_dig("t6 b2", 4'b0100, 5);
    #5;
    rst_n_i = 1'b0;
    hold_i  = 4'b0000;
    #1;
    chk("t6 rst digitize", digitize_o, 0);
    chk("t6 rst ready", event_ready_o, 0);
    chk("t6 rst buf", event_buf_o, 0);
    chk("t6 rst busy", busy_o, 0);
    chk("t6 rst err", err_o, 0);
    chk("t6 rst dup", dup_cnt_o, 0);
    tick();
    rst_n_i = 1'b1;
    tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("t6 late done ignored", event_ready_o, 0);
    repeat (6) tick();
    chk("t6 no strobe", digitize_o, 0);
    $display("txn t6: reset during WAIT_DONE, buffer abandoned");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
